// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser
// Description : Byte-level frame decoder behind a UART receiver. Hunts for a
//               sync byte, collects a length-prefixed payload with an 8-bit
//               additive checksum, buffers it and releases it on a
//               valid/ready stream only when the checksum matches.
//               Optional macro FRAME_TIMEOUT_EN enables an inter-byte
//               timeout inside a frame (oTimeout is tied 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 125_000
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic [7:0] iRxByte,
  input  logic       iRxDone,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oLast,
  output logic       oLenErr,
  output logic       oChkErr,
  output logic       oOverrun,
  output logic       oTimeout
);

  // Counter width holds 0..MAX_LEN; buffer address only needs 0..MAX_LEN-1.
  localparam int unsigned IW        = $clog2(MAX_LEN + 1);
  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = MAX_LEN[7:0];

  // Reject parameter values the byte-wide LEN field or the timeout cannot express.
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_badMaxLen
    $error("uart_frame_parser: MAX_LEN must be in 1..255");
  end
  if (TIMEOUT_CLKS < 2) begin : g_badTimeout
    $error("uart_frame_parser: TIMEOUT_CLKS must be at least 2");
  end

  typedef enum logic [2:0] {
    sHUNT    = 3'd0,
    sLEN     = 3'd1,
    sPAYLOAD = 3'd2,
    sCHK     = 3'd3,
    sDRAIN   = 3'd4
  } state_t;

  state_t        rState;
  state_t        wStateNext;
  logic [IW-1:0] rLen;
  logic [IW-1:0] rIdx;
  logic [IW-1:0] rRd;
  logic [7:0]    rSum;
  logic [7:0]    rBuf [MAX_LEN];

  logic rLenErr;
  logic rChkErr;
  logic rOverrun;

  logic wLenErr;
  logic wChkErr;
  logic wOverrun;
  logic wLoadLen;
  logic wPayWr;
  logic wStartDrain;
  logic wXfer;
  logic wLastXfer;
  logic wTimeoutHit;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

  logic [TW-1:0] rIdle;
  logic          rTimeout;
  logic          wInFrame;

  assign wInFrame    = (rState == sLEN) || (rState == sPAYLOAD) || (rState == sCHK);
  assign wTimeoutHit = wInFrame && !iRxDone && (rIdle == TW'(TIMEOUT_CLKS - 1));

  // Idle-gap counter: runs only mid-frame, restarts on every received byte.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rIdle    <= '0;
      rTimeout <= 1'b0;
    end else begin
      rTimeout <= wTimeoutHit;
      if (iRxDone || !wInFrame || wTimeoutHit) begin
        rIdle <= '0;
      end else begin
        rIdle <= rIdle + TW'(1);
      end
    end
  end

  assign oTimeout = rTimeout;
`else
  assign wTimeoutHit = 1'b0;
  assign oTimeout    = 1'b0;
`endif

  // Next-state and per-cycle control decode.
  always_comb begin
    wStateNext  = rState;
    wLenErr     = 1'b0;
    wChkErr     = 1'b0;
    wOverrun    = 1'b0;
    wLoadLen    = 1'b0;
    wPayWr      = 1'b0;
    wStartDrain = 1'b0;
    wXfer       = 1'b0;
    wLastXfer   = 1'b0;
    case (rState)
      sHUNT: begin
        if (iRxDone && (iRxByte == SYNC_BYTE)) begin
          wStateNext = sLEN;
        end
      end
      sLEN: begin
        if (iRxDone) begin
          if ((iRxByte == 8'd0) || (iRxByte > MAX_LEN_B)) begin
            wLenErr    = 1'b1;
            wStateNext = sHUNT;
          end else begin
            wLoadLen   = 1'b1;
            wStateNext = sPAYLOAD;
          end
        end
      end
      sPAYLOAD: begin
        if (iRxDone) begin
          wPayWr = 1'b1;
          if (rIdx == (rLen - IW'(1))) begin
            wStateNext = sCHK;
          end
        end
      end
      sCHK: begin
        if (iRxDone) begin
          if (iRxByte == rSum) begin
            wStartDrain = 1'b1;
            wStateNext  = sDRAIN;
          end else begin
            wChkErr    = 1'b1;
            wStateNext = sHUNT;
          end
        end
      end
      sDRAIN: begin
        // Any byte arriving while draining, even on the final transfer, is lost.
        wOverrun  = iRxDone;
        wXfer     = iReady;
        wLastXfer = iReady && (rRd == (rLen - IW'(1)));
        if (wLastXfer) begin
          wStateNext = sHUNT;
        end
      end
      default: begin
        wStateNext = sHUNT;
      end
    endcase
    if (wTimeoutHit) begin
      wStateNext = sHUNT;
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rState <= sHUNT;
    end else begin
      rState <= wStateNext;
    end
  end

  // Length, write index, running sum and drain read index.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rLen <= '0;
      rIdx <= '0;
      rRd  <= '0;
      rSum <= '0;
    end else begin
      if (wLoadLen) begin
        rLen <= iRxByte[IW-1:0];
        rSum <= iRxByte;
        rIdx <= '0;
      end else if (wPayWr) begin
        rSum <= rSum + iRxByte;
        rIdx <= rIdx + IW'(1);
      end
      if (wStartDrain) begin
        rRd <= '0;
      end else if (wXfer) begin
        rRd <= wLastXfer ? '0 : (rRd + IW'(1));
      end
    end
  end

  // Payload storage; contents are only read after being written this frame.
  always_ff @(posedge iClk) begin
    if (wPayWr) begin
      rBuf[rIdx[AW-1:0]] <= iRxByte;
    end
  end

  // Error pulses appear in the cycle after the offending byte.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rLenErr  <= 1'b0;
      rChkErr  <= 1'b0;
      rOverrun <= 1'b0;
    end else begin
      rLenErr  <= wLenErr;
      rChkErr  <= wChkErr;
      rOverrun <= wOverrun;
    end
  end

  assign oLenErr  = rLenErr;
  assign oChkErr  = rChkErr;
  assign oOverrun = rOverrun;
  assign oValid   = (rState == sDRAIN);
  assign oData    = oValid ? rBuf[rRd[AW-1:0]] : 8'd0;
  assign oLast    = oValid && (rRd == (rLen - IW'(1)));

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_parser
// Description : Self-checking bench for uart_frame_parser. Frames are built
//               from random lengths and payloads; expected output bytes and
//               error-pulse counts are derived from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

  localparam int MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       iClk = 1'b0;
  logic       iRstn = 1'b0;
  logic [7:0] iRxByte = 8'd0;
  logic       iRxDone = 1'b0;
  logic       iReady = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oLast;
  logic       oLenErr;
  logic       oChkErr;
  logic       oOverrun;
  logic       oTimeout;

  int checks = 0;
  int errors = 0;

  // Expected stream entries are {last, data}.
  logic [8:0] expQ [$];
  int expLen = 0, expChk = 0, expOvr = 0, expTo = 0;
  int obsLen = 0, obsChk = 0, obsOvr = 0, obsTo = 0;

  bit         prevStall = 1'b0;
  logic [7:0] prevData = 8'd0;
  logic       prevLast = 1'b0;

  uart_frame_parser #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLKS(50)
  ) dut (
    .iClk    (iClk),
    .iRstn   (iRstn),
    .iRxByte (iRxByte),
    .iRxDone (iRxDone),
    .oData   (oData),
    .oValid  (oValid),
    .iReady  (iReady),
    .oLast   (oLast),
    .oLenErr (oLenErr),
    .oChkErr (oChkErr),
    .oOverrun(oOverrun),
    .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  // Output monitor on the falling edge: scoreboard, stall stability, pulse counts.
  always @(negedge iClk) begin
    if (!iRstn) begin
      prevStall = 1'b0;
    end else begin
      obsLen += int'(oLenErr);
      obsChk += int'(oChkErr);
      obsOvr += int'(oOverrun);
      obsTo  += int'(oTimeout);
      if (prevStall) begin
        checks++;
        assert (oValid === 1'b1 && oData === prevData && oLast === prevLast)
        else begin
          errors++;
          $error("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 oValid, oData, oLast, prevData, prevLast);
        end
      end
      if (oValid === 1'b1 && iReady === 1'b1) begin
        checks++;
        assert (expQ.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_out got d=%h l=%b exp no output", oData, oLast);
        end
        if (expQ.size() != 0) begin
          logic [8:0] e;
          e = expQ.pop_front();
          checks++;
          assert ({oLast, oData} === e)
          else begin
            errors++;
            $error("FAIL out_byte got l=%b d=%h exp l=%b d=%h", oLast, oData, e[8], e[7:0]);
          end
        end
      end
      prevStall = (oValid === 1'b1) && (iReady === 1'b0);
      prevData  = oData;
      prevLast  = oLast;
    end
  end

  // Global safety net against a hung simulation.
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    iRxByte = b;
    iRxDone = 1'b1;
    @(posedge iClk);
    #1;
    iRxDone = 1'b0;
    iRxByte = 8'($urandom);
  endtask

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, want);
    end
  endtask

  task automatic checkCounters();
    tick(2);
    chk("len_err_count", obsLen, expLen);
    chk("chk_err_count", obsChk, expChk);
    chk("overrun_count", obsOvr, expOvr);
    chk("timeout_count", obsTo, expTo);
  endtask

  // Wait for every expected byte to leave, then confirm the stream went idle.
  task automatic waitDrain(input bit rndReady);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      iReady = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      n++;
    end
    chk("drain_done", expQ.size(), 0);
    chk("valid_low_after_drain", int'(oValid), 0);
    iReady = 1'b1;
  endtask

  // Build one frame from its parameters and predict the outcome.
  task automatic runFrame(input int len, input bit badChk, input bit ovr, input bit rndReady);
    logic [7:0] pay [$];
    logic [7:0] sum, cb;
    int junk;
    junk = $urandom_range(0, 3);
    for (int i = 0; i < junk; i++) begin
      logic [7:0] j;
      j = 8'($urandom);
      if (j == SYNC) j = 8'h00;
      sendByte(j);
    end
    sendByte(SYNC);
    tick($urandom_range(0, 2));
    sendByte(8'(len));
    if (len == 0 || len > MAXL) begin
      expLen++;
    end else begin
      sum = 8'(len);
      for (int i = 0; i < len; i++) begin
        pay.push_back(8'($urandom));
        sum = sum + pay[i];
      end
      for (int i = 0; i < len; i++) begin
        tick($urandom_range(0, 2));
        sendByte(pay[i]);
      end
      cb = badChk ? (sum ^ 8'($urandom_range(1, 255))) : sum;
      if (badChk) begin
        expChk++;
      end else begin
        for (int i = 0; i < len; i++) expQ.push_back({(i == len - 1), pay[i]});
      end
      iReady = ovr ? 1'b0 : 1'($urandom_range(0, 1));
      tick($urandom_range(0, 2));
      sendByte(cb);
      if (ovr && !badChk) begin
        sendByte(8'($urandom));
        expOvr++;
      end
    end
    waitDrain(rndReady);
    checkCounters();
  endtask

  initial begin
    // Reset state
    iRstn = 1'b0;
    tick(3);
    @(negedge iClk);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_data", int'(oData), 0);
    chk("rst_last", int'(oLast), 0);
    chk("rst_pulses", int'({oLenErr, oChkErr, oOverrun, oTimeout}), 0);
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
    tick(2);

    // Junk then a good 3-byte frame drained back to back
    iReady = 1'b1;
    sendByte(8'h00); sendByte(8'hFF); sendByte(8'hA5); sendByte(8'h03);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    expQ.push_back({1'b0, 8'h11});
    expQ.push_back({1'b0, 8'h22});
    expQ.push_back({1'b1, 8'h33});
    sendByte(8'h69);
    waitDrain(1'b0);
    checkCounters();

    // Bad checksum: nothing emitted
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11);
    sendByte(8'h22); sendByte(8'h33); sendByte(8'h6A);
    expChk++;
    checkCounters();

    // Length zero and length above maximum
    sendByte(8'hA5); sendByte(8'h00); expLen++;
    sendByte(8'hA5); sendByte(8'h11); expLen++;
    checkCounters();

    // Stalled drain with a sync byte arriving mid-stall
    iReady = 1'b0;
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h01); sendByte(8'h02);
    expQ.push_back({1'b0, 8'h01});
    expQ.push_back({1'b1, 8'h02});
    sendByte(8'h05);
    @(negedge iClk);
    chk("stall_first_valid", int'(oValid), 1);
    chk("stall_first_data", int'(oData), 8'h01);
    @(posedge iClk);
    #1;
    sendByte(8'hA5);
    expOvr++;
    tick(8);
    @(negedge iClk);
    chk("stall_hold_data", int'(oData), 8'h01);
    chk("stall_hold_last", int'(oLast), 0);
    @(posedge iClk);
    #1;
    waitDrain(1'b0);
    checkCounters();

    // Length boundaries
    runFrame(1, 1'b0, 1'b0, 1'b1);
    runFrame(MAXL, 1'b0, 1'b0, 1'b1);
    runFrame(MAXL + 1, 1'b0, 1'b0, 1'b1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(MAXL + 1, 255);
      else len = $urandom_range(1, MAXL);
      runFrame(len, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Reset in the middle of a drain discards the rest of the frame
    iReady = 1'b0;
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h10); sendByte(8'h20); sendByte(8'h30);
    sendByte(8'h63);
    @(negedge iClk);
    chk("pre_reset_valid", int'(oValid), 1);
    iRstn = 1'b0;
    #1;
    chk("reset_valid_drop", int'(oValid), 0);
    expQ.delete();
    tick(3);
    iRstn = 1'b1;
    iReady = 1'b1;
    tick(10);
    chk("post_reset_idle", int'(oValid), 0);
    checkCounters();
    runFrame(3, 1'b0, 1'b0, 1'b0);

`ifdef FRAME_TIMEOUT_EN
    // Stalled partial frame times out, next frame decodes cleanly
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h01);
    expTo++;
    tick(60);
    checkCounters();
    expQ.push_back({1'b1, 8'h7E});
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h7E); sendByte(8'h7F);
    waitDrain(1'b0);
    checkCounters();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
